// File: rtl/seq_det_pkg.sv
// seq_det_pkg -- shared constants for the serial pattern detector.
//   PAT_LEN_MIN / PAT_LEN_MAX : legal pattern-length range
//   fill_w()                  : width of a counter that must hold 0..pat_len
package seq_det_pkg;

  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 16;

  // The fill counter saturates at pat_len, so it needs pat_len+1 codes.
  function automatic int fill_w(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if -- serial data / config / result bundle of the detector.
//   in_seq      : serial data bit
//   in_en       : qualifies in_seq
//   overlap     : 1 = overlapping detection, 0 = non-overlapping
//   cfg_load    : load cfg_pattern on this edge
//   cfg_pattern : new pattern, bit [PAT_LEN-1] is received first
//   out_seq     : registered one-cycle match pulse
//   match_cnt   : saturating match count (zero unless SEQ_DET_COUNT_EN)
// Modports: master = stimulus side, slave = detector side.
interface seq_detector_param_if #(
  parameter int PAT_LEN = 3,
  parameter int CNT_W   = 8
);
  logic               in_seq;
  logic               in_en;
  logic               overlap;
  logic               cfg_load;
  logic [PAT_LEN-1:0] cfg_pattern;
  logic               out_seq;
  logic [CNT_W-1:0]   match_cnt;

  modport master (
    output in_seq, in_en, overlap, cfg_load, cfg_pattern,
    input  out_seq, match_cnt
  );

  modport slave (
    input  in_seq, in_en, overlap, cfg_load, cfg_pattern,
    output out_seq, match_cnt
  );
endinterface

// File: rtl/seq_detector_param.sv
// seq_detector_param -- parameterised serial pattern detector.
// Shifts qualified bits into a PAT_LEN-bit history and pulses out_seq for one
// cycle when the history equals the active pattern and at least PAT_LEN bits
// have been collected since reset / load / the last non-overlapping match.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : seq_detector_param_if.slave (data, config, out_seq, match_cnt)
// Build option: define SEQ_DET_COUNT_EN to compile in the saturating match
// counter; otherwise match_cnt is tied to zero and no counter flops exist.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PAT_RST = 3'b101,
  parameter int               CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  seq_detector_param_if.slave   bus
);

  localparam int                FILL_W    = fill_w(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX) begin : g_bad_len
    $error("seq_detector_param: PAT_LEN out of range");
  end

  logic [PAT_LEN-1:0] r_hist, r_pat;
  logic [FILL_W-1:0]  r_fill;
  logic               r_out;

  logic [PAT_LEN-1:0] w_shift, w_hist_nxt, w_pat_nxt;
  logic [FILL_W-1:0]  w_fill_inc, w_fill_nxt;
  logic               w_match;

  assign w_shift    = {r_hist[PAT_LEN-2:0], bus.in_seq};
  assign w_fill_inc = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FILL_W'(1);

  // Load has priority over data: the bit on a load edge is dropped even if
  // in_en is high, and the fill restart guarantees no stale match.
  always_comb begin
    w_hist_nxt = r_hist;
    w_fill_nxt = r_fill;
    w_pat_nxt  = r_pat;
    w_match    = 1'b0;
    if (bus.cfg_load) begin
      w_pat_nxt  = bus.cfg_pattern;
      w_fill_nxt = '0;
    end else if (bus.in_en) begin
      w_hist_nxt = w_shift;
      w_fill_nxt = w_fill_inc;
      w_match    = (w_shift == r_pat) && (w_fill_inc == FILL_FULL);
      // Non-overlapping: history bits may stay, the cleared fill masks them.
      if (w_match && !bus.overlap) w_fill_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= '0;
      r_fill <= '0;
      r_pat  <= PAT_RST;
      r_out  <= 1'b0;
    end else begin
      r_hist <= w_hist_nxt;
      r_fill <= w_fill_nxt;
      r_pat  <= w_pat_nxt;
      r_out  <= w_match;
    end
  end

  assign bus.out_seq = r_out;

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Saturates at all-ones; cfg_load intentionally leaves it alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     r_cnt <= '0;
    else if (w_match && ~&r_cnt)    r_cnt <= r_cnt + CNT_W'(1);
  end

  assign bus.match_cnt = r_cnt;
`else
  assign bus.match_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_detector_param_if #(.PAT_LEN(3), .CNT_W(2)) bus0 ();
  seq_detector_param_if #(.PAT_LEN(4), .CNT_W(8)) bus1 ();

  seq_detector_param #(.PAT_LEN(3), .PAT_RST(3'b101), .CNT_W(2)) dut0 (
    .clk(clk), .reset(rst_n), .bus(bus0));
  seq_detector_param #(.PAT_LEN(4), .PAT_RST(4'b0110), .CNT_W(8)) dut1 (
    .clk(clk), .reset(rst_n), .bus(bus1));

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_on = 0;

  // Reference model: the list of bits received since the last clear point,
  // trimmed to the pattern length; a match is "tail equals pattern".
  int s0[$];
  int s1[$];
  int pat0 = 5, pat1 = 6;
  int cnt0 = 0, cnt1 = 0;
  bit n_out0, n_out1;
  bit e_out0 = 0, e_out1 = 0;
  int e_cnt0 = 0, e_cnt1 = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit tail_eq(input int s[$], input int len, input int pat);
    if (s.size() < len) return 1'b0;
    for (int i = 0; i < len; i++)
      if (s[s.size() - len + i] != ((pat >> (len - 1 - i)) & 1)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input bit b, input bit en, input bit ov, input bit ld);
    n_out0 = 0;
    n_out1 = 0;
    if (ld) begin
      s0.delete();
      s1.delete();
      pat0 = int'(bus0.cfg_pattern);
      pat1 = int'(bus1.cfg_pattern);
    end else if (en) begin
      s0.push_back(int'(b));
      if (s0.size() > 3) void'(s0.pop_front());
      if (tail_eq(s0, 3, pat0)) begin
        n_out0 = 1;
        if (cnt0 < 3) cnt0++;
        if (!ov) s0.delete();
      end
      s1.push_back(int'(b));
      if (s1.size() > 4) void'(s1.pop_front());
      if (tail_eq(s1, 4, pat1)) begin
        n_out1 = 1;
        if (cnt1 < 255) cnt1++;
        if (!ov) s1.delete();
      end
    end
  endtask

  // One clock of stimulus; x0/x1 >= 0 are hand-computed out_seq expectations.
  task automatic cyc(input bit b, input bit en, input bit ov, input bit ld,
                     input int x0, input int x1);
    bus0.in_seq = b;  bus0.in_en = en;  bus0.overlap = ov;  bus0.cfg_load = ld;
    bus1.in_seq = b;  bus1.in_en = en;  bus1.overlap = ov;  bus1.cfg_load = ld;
    model_step(b, en, ov, ld);
    @(posedge clk);
    e_out0 = n_out0;
    e_out1 = n_out1;
`ifdef SEQ_DET_COUNT_EN
    e_cnt0 = cnt0;
    e_cnt1 = cnt1;
`else
    e_cnt0 = 0;
    e_cnt1 = 0;
`endif
    #1;
    if (x0 >= 0) chk("lit_out0", int'(bus0.out_seq), x0);
    if (x1 >= 0) chk("lit_out1", int'(bus1.out_seq), x1);
  endtask

  // Called just after a rising edge; holds reset low for ncyc edges.
  task automatic do_reset(input int ncyc);
    rst_n = 1'b0;
    s0.delete();  s1.delete();
    pat0 = 5;  pat1 = 6;
    cnt0 = 0;  cnt1 = 0;
    e_out0 = 0;  e_out1 = 0;  e_cnt0 = 0;  e_cnt1 = 0;
    repeat (ncyc) @(posedge clk);
    #1;
    chk("rst_out0", int'(bus0.out_seq), 0);
    chk("rst_cnt0", int'(bus0.match_cnt), 0);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("out0", int'(bus0.out_seq), int'(e_out0));
      chk("out1", int'(bus1.out_seq), int'(e_out1));
      chk("cnt0", int'(bus0.match_cnt), e_cnt0);
      chk("cnt1", int'(bus1.match_cnt), e_cnt1);
    end
  end

  initial begin
    int exp_sat;
    rst_n = 1'b1;
    bus0.in_seq = 0; bus0.in_en = 0; bus0.overlap = 0; bus0.cfg_load = 0;
    bus1.in_seq = 0; bus1.in_en = 0; bus1.overlap = 0; bus1.cfg_load = 0;
    bus0.cfg_pattern = 3'b101;
    bus1.cfg_pattern = 4'b0110;
    #1;
    rst_n = 1'b0;
    #1;
    cmp_on = 1;
    @(posedge clk); #1;
    do_reset(2);

    // Overlapping: 1,0,1,0,1 -> pulses after bits 3 and 5
    cyc(1,1,1,0, 0,-1); cyc(0,1,1,0, 0,-1); cyc(1,1,1,0, 1,-1);
    cyc(0,1,1,0, 0,-1); cyc(1,1,1,0, 1,-1);

    // Non-overlapping: 1,0,1,1,0,1 -> bits 3 and 6
    do_reset(1);
    cyc(1,1,0,0, 0,-1); cyc(0,1,0,0, 0,-1); cyc(1,1,0,0, 1,-1);
    cyc(1,1,0,0, 0,-1); cyc(0,1,0,0, 0,-1); cyc(1,1,0,0, 1,-1);
    // Non-overlapping: 1,0,1,0,1 -> bit 3 only
    do_reset(1);
    cyc(1,1,0,0, 0,-1); cyc(0,1,0,0, 0,-1); cyc(1,1,0,0, 1,-1);
    cyc(0,1,0,0, 0,-1); cyc(1,1,0,0, 0,-1);

    // Enable gap: 1, three idle cycles with junk data, 0, 1
    do_reset(1);
    cyc(1,1,1,0, 0,-1);
    cyc(0,0,1,0, 0,-1); cyc(1,0,1,0, 0,-1); cyc(1,0,1,0, 0,-1);
    cyc(0,1,1,0, 0,-1); cyc(1,1,1,0, 1,-1);

    // Reset mid-sequence discards 1,0
    do_reset(1);
    cyc(1,1,1,0, 0,-1); cyc(0,1,1,0, 0,-1);
    do_reset(1);
    cyc(1,1,1,0, 0,-1); cyc(0,1,1,0, 0,-1); cyc(1,1,1,0, 1,-1);

    // Load edge: bit is dropped and fill restarts
    do_reset(1);
    bus0.cfg_pattern = 3'b101;
    bus1.cfg_pattern = 4'b1100;
    cyc(1,1,1,0, 0,-1); cyc(0,1,1,0, 0,-1);
    cyc(1,1,1,1, 0, 0);
    cyc(0,1,1,0, 0,-1); cyc(1,1,1,0, 0,-1);
    cyc(0,1,1,0, 0,-1); cyc(1,1,1,0, 1,-1);
    // PAT_LEN=4: load 1100 with in_seq=1, then 1,1,0,0
    cyc(1,1,1,1, 0, 0);
    cyc(1,1,1,0, -1,0); cyc(1,1,1,0, -1,0);
    cyc(0,1,1,0, -1,0); cyc(0,1,1,0, -1,1);

    // Counter saturation: eleven bits, five matches on a 2-bit counter
    do_reset(1);
    for (int i = 0; i < 11; i++) cyc(((i % 2) == 0), 1, 1, 0, -1, -1);
`ifdef SEQ_DET_COUNT_EN
    exp_sat = 3;
`else
    exp_sat = 0;
`endif
    chk("sat_cnt0", int'(bus0.match_cnt), exp_sat);
    do_reset(1);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1 + ($urandom % 2));
      end else begin
        bit ld;
        ld = ($urandom % 32) == 0;
        if (ld) begin
          bus0.cfg_pattern = 3'($urandom);
          bus1.cfg_pattern = 4'($urandom);
        end
        cyc(1'($urandom), ($urandom % 4) != 0, 1'($urandom), ld, -1, -1);
      end
    end

    @(negedge clk);
    cmp_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter PAT_LEN, default 3: pattern length in bits; legal range 2..16.
REQ-002 Parameter PAT_RST, default 3'b101 (width PAT_LEN): pattern loaded at reset.
REQ-003 Parameter CNT_W, default 8: width of match_cnt.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1: asynchronous, active-low reset.
REQ-006 Port in_seq  input  1: serial data bit.
REQ-007 Port in_en  input  1: qualifies in_seq; a bit is consumed only on an edge where in_en=1.
REQ-008 Port overlap  input  1: 1 = overlapping detection, 0 = non-overlapping; sampled per consumed bit.
REQ-009 Port cfg_load  input  1: load cfg_pattern on this edge.
REQ-010 Port cfg_pattern  input  PAT_LEN: new pattern; bit [PAT_LEN-1] is the first bit received, bit [0] the last.
REQ-011 Port out_seq  output  1: registered one-cycle match pulse.
REQ-012 Port match_cnt  output  CNT_W: saturating match count (REQ-027 only).

Function
REQ-013 Block SHALL hold a PAT_LEN-bit history shift register, a fill counter (0..PAT_LEN), and the active pattern register.
REQ-014 On a consumed bit, history SHALL shift left with in_seq entering bit [0]; fill SHALL increment, saturating at PAT_LEN.
REQ-015 A match SHALL occur on a consumed bit when the post-shift history equals the pattern and post-increment fill equals PAT_LEN.
REQ-016 out_seq SHALL be 1 for exactly the one cycle following the edge that consumed the match-completing bit, and 0 otherwise.
REQ-017 Latency: completing bit sampled at edge N -> out_seq high from edge N to edge N+1.
REQ-018 Overlap=1: after a match, history and fill SHALL be kept, so consecutive matches may share bits.
REQ-019 Overlap=0: on a match, fill SHALL clear to 0; the next match needs PAT_LEN fresh bits.
REQ-020 Edges with in_en=0 SHALL leave history, fill and pattern unchanged and drive out_seq=0.
REQ-021 cfg_load=1 SHALL load cfg_pattern, clear fill to 0, and drive out_seq=0; in_seq on that edge SHALL be discarded regardless of in_en.
REQ-022 No match SHALL be reported while fill < PAT_LEN, including just after reset or a load.

Reset
REQ-023 With reset=0, asynchronously: out_seq=0, history=0, fill=0, pattern=PAT_RST, match_cnt=0.
REQ-024 A reset asserted mid-sequence SHALL discard all partial progress; no pulse is generated from bits received before the reset.
REQ-025 The first edge with reset=1 SHALL already consume input normally.

Configuration
REQ-026 Macro SEQ_DET_COUNT_EN selects whether the match counter is compiled in.
REQ-027 With the macro defined, match_cnt SHALL increment by 1 on every match, saturating at 2^CNT_W-1; cfg_load does not clear it.
REQ-028 Without the macro, match_cnt SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-029 Package seq_det_pkg SHALL hold the PAT_LEN range limits and the fill-counter width function (clog2(PAT_LEN+1)).
REQ-030 The design SHALL be a single module with no sub-modules; the comparator is inline.

Verification
REQ-031 Default params, overlap=1, in_en=1, stream 1,0,1,0,1 -> out_seq pulses after bit 3 and after bit 5.
REQ-032 overlap=0, stream 1,0,1,1,0,1 -> pulses after bits 3 and 6 only; stream 1,0,1,0,1 -> pulse after bit 3 only.
REQ-033 Stream 1,(in_en=0 for 3 cycles),0,1 -> single pulse after the final 1; no pulse during the gap.
REQ-034 Stream 1,0, then reset low for 1 cycle, then 1 -> no pulse; then 0,1 -> pulse.
REQ-035 PAT_LEN=4 instance: cfg_load 4'b1100 with in_seq=1, then stream 1,1,0,0 -> pulse after the last 0; the bit on the load edge is not counted.
REQ-036 SEQ_DET_COUNT_EN, CNT_W=2, overlap=1, stream 1,0,1,0,1,0,1,0,1,0,1 (5 matches) -> match_cnt=3 (saturated); reset -> 0.
